// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: input handshake, stall/flush controls, per-stage taps and perf counters of the chain
interface pipe_stage_chain_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic [DEPTH-1:0]       stall;
  logic [DEPTH-1:0]       flush;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [CNT_W-1:0]       perf_retire;
  logic [CNT_W-1:0]       perf_stall;
  logic [CNT_W-1:0]       perf_flush;
  modport master (
    output in_valid, in_data, stall, flush,
    input  in_ready, stage_valid, stage_data, out_valid, out_data, perf_retire, perf_stall, perf_flush
  );
  modport slave (
    input  in_valid, in_data, stall, flush,
    output in_ready, stage_valid, stage_data, out_valid, out_data, perf_retire, perf_stall, perf_flush
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage in-order register chain with per-stage stall/flush and stage taps.
// Define PIPE_PERF_CNT_EN to add saturating retire/stall/flush counters; otherwise perf ports read 0.
module pipe_stage_chain #(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] NOP_VAL = '0,
  parameter int               CNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  pipe_stage_chain_if.slave p
);
  logic [DEPTH-1:0]            valid_q, valid_d, hold, kill, prev_valid, prev_hold;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d, prev_data;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hold[i] = |(p.stall >> i);
      kill[i] = |(p.flush >> i);
    end
  end
  // Each stage sees its upstream neighbour; stage 0's upstream is the input port.
  // Invalid stages always carry NOP_VAL, so copying an upstream bubble keeps that true.
  always_comb begin
    prev_valid = {valid_q[DEPTH-2:0], p.in_valid};
    prev_hold  = {hold[DEPTH-2:0], 1'b0};
    prev_data  = {data_q[DEPTH-2:0], p.in_valid ? p.in_data : NOP_VAL};
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = kill[i] ? 1'b0 : hold[i] ? valid_q[i] : prev_valid[i] & !prev_hold[i];
      data_d[i]  = (kill[i] || (!hold[i] && prev_hold[i])) ? NOP_VAL : hold[i] ? data_q[i] : prev_data[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= {DEPTH{NOP_VAL}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign p.in_ready    = !hold[0] && !kill[0];
  assign p.stage_valid = valid_q;
  assign p.stage_data  = data_q;
  assign p.out_valid   = valid_q[DEPTH-1];
  assign p.out_data    = data_q[DEPTH-1];
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] retire_q, stall_q, flush_q;
  logic             retire;
  assign retire = valid_q[DEPTH-1] & !p.stall[DEPTH-1] & !p.flush[DEPTH-1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      retire_q <= retire_q + CNT_W'(retire && !(&retire_q));
      stall_q  <= stall_q + CNT_W'((|p.stall) && !(&stall_q));
      flush_q  <= flush_q + CNT_W'((|p.flush) && !(&flush_q));
    end
  end
  assign p.perf_retire = retire_q;
  assign p.perf_stall  = stall_q;
  assign p.perf_flush  = flush_q;
`else
  assign p.perf_retire = '0;
  assign p.perf_stall  = '0;
  assign p.perf_flush  = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed and randomized checks of pipe_stage_chain against a segment-level model
module tb_pipe_stage_chain;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  pipe_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP_VAL('0), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .p(bus)
  );
  always #5 clk = ~clk;
  logic             m_valid [DEPTH];
  logic [WIDTH-1:0] m_data  [DEPTH];
  logic [CNT_W-1:0] m_retire, m_stall, m_flush;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction
  // The chain splits into a frozen segment (stages up to the oldest stalled one) and a moving
  // segment above it; everything up to the oldest flushed stage is then wiped.
  function automatic void model_edge();
    int s = -1;
    int f = -1;
    logic             nv [DEPTH];
    logic [WIDTH-1:0] nd [DEPTH];
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_valid[i] = 1'b0;
        m_data[i] = '0;
      end
      m_retire = '0; m_stall = '0; m_flush = '0;
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.stall[i]) s = i;
      if (bus.flush[i]) f = i;
    end
    if (PERF_EN) begin
      if (m_valid[DEPTH-1] && s < DEPTH-1 && f < DEPTH-1) m_retire = sat_inc(m_retire);
      if (s >= 0) m_stall = sat_inc(m_stall);
      if (f >= 0) m_flush = sat_inc(m_flush);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i <= s) begin nv[i] = m_valid[i]; nd[i] = m_data[i]; end
      else if (i == 0) begin nv[i] = bus.in_valid; nd[i] = bus.in_valid ? bus.in_data : '0; end
      else if (i - 1 == s) begin nv[i] = 1'b0; nd[i] = '0; end
      else begin nv[i] = m_valid[i-1]; nd[i] = m_data[i-1]; end
    end
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = (i <= f) ? 1'b0 : nv[i];
      m_data[i] = (i <= f) ? '0 : nd[i];
    end
  endfunction
  function automatic logic [DEPTH-1:0] exp_valid();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_valid[i];
    return v;
  endfunction
  function automatic logic [DEPTH*WIDTH-1:0] exp_data();
    logic [DEPTH*WIDTH-1:0] d;
    for (int i = 0; i < DEPTH; i++) d[i*WIDTH +: WIDTH] = m_data[i];
    return d;
  endfunction
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [DEPTH-1:0] s, input logic [DEPTH-1:0] f);
    bus.in_valid = v;
    bus.in_data = d;
    bus.stall = s;
    bus.flush = f;
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0);
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'hFFFF, '0, '0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    tick();
    tick();
    checks++;
    if (bus.stage_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", bus.stage_valid); end
    checks++;
    if (bus.stage_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.stage_data); end
    checks++;
    if ({bus.perf_retire, bus.perf_stall, bus.perf_flush} !== '0)
      begin errors++; $display("FAIL reset_perf: got %h/%h/%h expected 0/0/0", bus.perf_retire, bus.perf_stall, bus.perf_flush); end
    rst_n = 1'b1;
  endtask
  task automatic test_fill();
    for (int k = 0; k < 10; k++) begin
      drive(k < 6, 32'hA0 + k, '0, '0);
      tick();
      checks++;
      if (bus.out_valid !== (k >= 3 && k <= 8)) begin errors++; $display("FAIL fill_out_valid edge %0d: got %b expected %b", k + 1, bus.out_valid, (k >= 3 && k <= 8)); end
      checks++;
      if (bus.out_data !== ((k >= 3 && k <= 8) ? 32'hA0 + k - 3 : 32'h0))
        begin errors++; $display("FAIL fill_out_data edge %0d: got %h expected %h", k + 1, bus.out_data, ((k >= 3 && k <= 8) ? 32'hA0 + k - 3 : 32'h0)); end
      checks++;
      if ({bus.stage_valid, bus.stage_data} !== {exp_valid(), exp_data()})
        begin errors++; $display("FAIL fill_state edge %0d: got %b %h expected %b %h", k + 1, bus.stage_valid, bus.stage_data, exp_valid(), exp_data()); end
    end
  endtask
  task automatic test_stall();
    logic [WIDTH-1:0] obs[$];
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'hA0 + k, '0, '0);
      tick();
    end
    if (bus.out_valid) obs.push_back(bus.out_data);
    drive(1'b1, 32'hA4, 4'b0010, '0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready); end
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bus.out_valid) obs.push_back(bus.out_data);
    end
    checks++;
    if ({bus.stage_valid[1:0], bus.stage_data[63:0]} !== {2'b11, 32'hA2, 32'hA3})
      begin errors++; $display("FAIL stall_hold: got %b %h expected 11 000000a2000000a3", bus.stage_valid[1:0], bus.stage_data[63:0]); end
    checks++;
    if ({bus.stage_valid, bus.stage_data} !== {exp_valid(), exp_data()})
      begin errors++; $display("FAIL stall_state: got %b %h expected %b %h", bus.stage_valid, bus.stage_data, exp_valid(), exp_data()); end
    drive(1'b0, '0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.out_valid) obs.push_back(bus.out_data);
    end
    checks++;
    if (obs.size() !== 4) begin errors++; $display("FAIL stall_exit_count: got %0d expected 4", obs.size()); end
    for (int k = 0; k < obs.size() && k < 4; k++) begin
      checks++;
      if (obs[k] !== 32'hA0 + k) begin errors++; $display("FAIL stall_exit_order %0d: got %h expected %h", k, obs[k], 32'hA0 + k); end
    end
  endtask
  task automatic test_flush_stall();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'hB0 + k, '0, '0);
      tick();
    end
    drive(1'b1, 32'hB4, 4'b0010, 4'b0100);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready); end
    tick();
    checks++;
    if (bus.stage_valid !== 4'b1000) begin errors++; $display("FAIL flush_valid: got %b expected 1000", bus.stage_valid); end
    checks++;
    if (bus.stage_data !== {32'hB1, 96'h0}) begin errors++; $display("FAIL flush_data: got %h expected %h", bus.stage_data, {32'hB1, 96'h0}); end
    checks++;
    if ({bus.stage_valid, bus.stage_data} !== {exp_valid(), exp_data()})
      begin errors++; $display("FAIL flush_state: got %b %h expected %b %h", bus.stage_valid, bus.stage_data, exp_valid(), exp_data()); end
  endtask
  task automatic test_reset_mid();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hC0 + k, 4'b0001, '0);
      tick();
    end
    rst_n = 1'b0;
    drive(1'b1, 32'hC3, 4'b1000, '0);
    tick();
    checks++;
    if ({bus.stage_valid, bus.stage_data} !== '0) begin errors++; $display("FAIL midreset_state: got %b %h expected all 0", bus.stage_valid, bus.stage_data); end
    checks++;
    if ({bus.perf_retire, bus.perf_stall, bus.perf_flush} !== '0)
      begin errors++; $display("FAIL midreset_perf: got %h/%h/%h expected 0/0/0", bus.perf_retire, bus.perf_stall, bus.perf_flush); end
    rst_n = 1'b1;
  endtask
  task automatic test_perf();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'hD0 + k, '0, '0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 4'b1000, '0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, '0, '0);
      tick();
    end
    drive(1'b0, '0, '0, 4'b0001);
    tick();
    drive(1'b0, '0, '0, '0);
    checks++;
    if (bus.stage_valid !== 4'b0000) begin errors++; $display("FAIL perf_drained: got %b expected 0000", bus.stage_valid); end
    checks++;
    if (bus.perf_retire !== (PERF_EN ? 16'd8 : 16'd0)) begin errors++; $display("FAIL perf_retire: got %0d expected %0d", bus.perf_retire, PERF_EN ? 8 : 0); end
    checks++;
    if (bus.perf_stall !== (PERF_EN ? 16'd3 : 16'd0)) begin errors++; $display("FAIL perf_stall: got %0d expected %0d", bus.perf_stall, PERF_EN ? 3 : 0); end
    checks++;
    if (bus.perf_flush !== (PERF_EN ? 16'd1 : 16'd0)) begin errors++; $display("FAIL perf_flush: got %0d expected %0d", bus.perf_flush, PERF_EN ? 1 : 0); end
  endtask
  task automatic test_random();
    logic [DEPTH-1:0] s, f;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < DEPTH; i++) begin
        s[i] = ($urandom_range(0, 7) == 0);
        f[i] = ($urandom_range(0, 15) == 0);
      end
      rst_n = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 3) != 0, $urandom, s, f);
      #1;
      checks++;
      if (bus.in_ready !== (s == '0 && f == '0)) begin errors++; $display("FAIL rand_in_ready cyc %0d: got %b expected %b", c, bus.in_ready, (s == '0 && f == '0)); end
      tick();
      checks++;
      if ({bus.stage_valid, bus.stage_data} !== {exp_valid(), exp_data()})
        begin errors++; $display("FAIL rand_state cyc %0d: got %b %h expected %b %h", c, bus.stage_valid, bus.stage_data, exp_valid(), exp_data()); end
      checks++;
      if ({bus.out_valid, bus.out_data} !== {m_valid[DEPTH-1], m_data[DEPTH-1]})
        begin errors++; $display("FAIL rand_out cyc %0d: got %b %h expected %b %h", c, bus.out_valid, bus.out_data, m_valid[DEPTH-1], m_data[DEPTH-1]); end
      checks++;
      if ({bus.perf_retire, bus.perf_stall, bus.perf_flush} !== {m_retire, m_stall, m_flush})
        begin errors++; $display("FAIL rand_perf cyc %0d: got %0d/%0d/%0d expected %0d/%0d/%0d", c, bus.perf_retire, bus.perf_stall, bus.perf_flush, m_retire, m_stall, m_flush); end
    end
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_data[i] = '0;
    end
    m_retire = '0; m_stall = '0; m_flush = '0;
    drive(1'b0, '0, '0, '0);
    test_reset();
    test_fill();
    test_stall();
    test_flush_stall();
    test_reset_mid();
    test_perf();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
